// File: rtl/game_pkg.sv
// Shared game geometry and direction codes used by the
// player mover and the collision detector.
package game_pkg;

   localparam logic [2:0] NO_ACTION = 3'd0;
   localparam logic [2:0] ATTACK    = 3'd1;
   localparam logic [2:0] UP        = 3'd2;
   localparam logic [2:0] DOWN      = 3'd3;
   localparam logic [2:0] LEFT      = 3'd4;
   localparam logic [2:0] RIGHT     = 3'd5;

   localparam int MAP_W     = 256;
   localparam int MAP_H     = 176;
   localparam int SPRITE_PX = 16;

   // Largest legal top-left corner for a sprite fully on the map
   localparam logic [8:0] X_MAX = 9'(MAP_W - SPRITE_PX);
   localparam logic [7:0] Y_MAX = 8'(MAP_H - SPRITE_PX);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_CHECK,
      S_APPLY,
      S_DONE
   } mv_state_e;

   function automatic logic is_move(input logic [2:0] d);
      return (d >= UP) && (d <= RIGHT);
   endfunction

   function automatic logic [2:0] opp_dir(input logic [2:0] d);
      logic [2:0] r;
      r = NO_ACTION;
      case (d)
         UP:      r = DOWN;
         DOWN:    r = UP;
         LEFT:    r = RIGHT;
         RIGHT:   r = LEFT;
         default: r = NO_ACTION;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/pos_clamp_step.sv
// Next position after moving dist_i pixels in dir_i,
// clamped so the sprite stays on the map.
module pos_clamp_step
   import game_pkg::*;
(
   input  logic [8:0] x_i,
   input  logic [7:0] y_i,
   input  logic [2:0] dir_i,
   input  logic [3:0] dist_i,
   output logic [8:0] x_o,
   output logic [7:0] y_o
);

   logic signed [10:0] tx;
   logic signed [9:0]  ty;
   logic signed [10:0] dx;
   logic signed [9:0]  dy;

   always_comb begin
      tx = $signed({2'b00, x_i});
      ty = $signed({2'b00, y_i});
      dx = $signed({7'b0000000, dist_i});
      dy = $signed({6'b000000, dist_i});
      case (dir_i)
         UP:      ty = ty - dy;
         DOWN:    ty = ty + dy;
         LEFT:    tx = tx - dx;
         RIGHT:   tx = tx + dx;
         default: ;
      endcase
   end

   // Signed headroom lets underflow clamp to 0 instead of wrapping
   always_comb begin
      if (tx < 0)
         x_o = '0;
      else if (tx > $signed({2'b00, X_MAX}))
         x_o = X_MAX;
      else
         x_o = tx[8:0];

      if (ty < 0)
         y_o = '0;
      else if (ty > $signed({2'b00, Y_MAX}))
         y_o = Y_MAX;
      else
         y_o = ty[7:0];
   end

endmodule

// File: rtl/player_mover.sv
// Per-frame player movement sequencer: drives the collision
// detector, then commits the step or applies knockback.
module player_mover
   import game_pkg::*;
#(
   parameter logic [8:0] START_X       = 9'd120,
   parameter logic [7:0] START_Y       = 8'd80,
   parameter int         STEP_PX       = 1,
   parameter int         KNOCKBACK_PX  = 8,
   parameter logic [5:0] INVULN_FRAMES = 6'd60,
   parameter logic [4:0] DONE_TIMEOUT  = 5'd31
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       frame_tick,
   input  logic [2:0] move_dir,
   input  logic       collision_done,
   input  logic       c_map_collision,
   input  logic       c_e1_collision,
   output logic [8:0] char_x,
   output logic [7:0] char_y,
   output logic [2:0] direction_char,
   output logic [2:0] facing_char,
   output logic       attack,
   output logic       collision_init,
   output logic       collision_enable,
   output logic       damage,
   output logic       invuln,
   output logic       busy,
   output logic       update_done
);

   mv_state_e  state_q, state_d;
   logic [8:0] x_q;
   logic [7:0] y_q;
   logic [2:0] face_q, dir_q;
   logic       attack_q, map_q, e1_q;
   logic [4:0] to_q;
   logic [5:0] inv_q;

   logic [8:0] step_x, kb_x;
   logic [7:0] step_y, kb_y;
   logic [2:0] kb_dir;
   logic       hit, timeout;

   assign timeout = (to_q == DONE_TIMEOUT - 5'd1);
   assign hit     = e1_q && (inv_q == '0);
   assign kb_dir  = opp_dir(face_q);

   pos_clamp_step u_step (
      .x_i    (x_q),
      .y_i    (y_q),
      .dir_i  (dir_q),
      .dist_i (4'(STEP_PX)),
      .x_o    (step_x),
      .y_o    (step_y)
   );

   pos_clamp_step u_kb (
      .x_i    (x_q),
      .y_i    (y_q),
      .dir_i  (kb_dir),
      .dist_i (4'(KNOCKBACK_PX)),
      .x_o    (kb_x),
      .y_o    (kb_y)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (frame_tick) state_d = S_INIT;
         S_INIT:  state_d = S_CHECK;
         S_CHECK: if (collision_done || timeout) state_d = S_APPLY;
         S_APPLY: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      collision_init   = (state_q == S_INIT);
      collision_enable = (state_q == S_CHECK);
      damage           = (state_q == S_APPLY) && hit;
      update_done      = (state_q == S_DONE);
      busy             = (state_q != S_IDLE);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         x_q      <= START_X;
         y_q      <= START_Y;
         face_q   <= DOWN;
         dir_q    <= NO_ACTION;
         attack_q <= 1'b0;
         map_q    <= 1'b0;
         e1_q     <= 1'b0;
         to_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (frame_tick) begin
                  dir_q    <= move_dir;
                  attack_q <= (move_dir == ATTACK);
               end
            end
            S_INIT: to_q <= '0;
            S_CHECK: begin
               to_q <= to_q + 5'd1;
               // A missing done is treated as a blocked step
               if (collision_done) begin
                  map_q <= c_map_collision;
                  e1_q  <= c_e1_collision;
               end else if (timeout) begin
                  map_q <= 1'b1;
                  e1_q  <= 1'b0;
               end
            end
            S_APPLY: begin
               attack_q <= 1'b0;
               if (hit) begin
                  x_q <= kb_x;
                  y_q <= kb_y;
               end else if (is_move(dir_q) && !map_q) begin
                  x_q <= step_x;
                  y_q <= step_y;
               end
               if (is_move(dir_q))
                  face_q <= dir_q;
            end
            default: ;
         endcase
      end
   end

   // A fresh hit reload beats a coincident tick decrement
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         inv_q <= '0;
      else if ((state_q == S_APPLY) && hit)
         inv_q <= INVULN_FRAMES;
      else if (frame_tick && (inv_q != '0))
         inv_q <= inv_q - 6'd1;
   end

   assign char_x         = x_q;
   assign char_y         = y_q;
   assign direction_char = dir_q;
   assign facing_char    = face_q;
   assign attack         = attack_q;
   assign invuln         = (inv_q != '0);

endmodule

// File: tb/tb_player_mover.sv
// Scoreboard bench for player_mover with a behavioural
// collision detector answering after a programmable delay.
module tb_player_mover;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       frame_tick = 1'b0;
   logic [2:0] move_dir = 3'd0;
   logic       collision_done = 1'b0;
   logic       c_map_collision = 1'b0;
   logic       c_e1_collision = 1'b0;
   logic [8:0] char_x;
   logic [7:0] char_y;
   logic [2:0] direction_char, facing_char;
   logic       attack, collision_init, collision_enable;
   logic       damage, invuln, busy, update_done;

   player_mover dut (
      .clock            (clock),
      .resetn           (resetn),
      .frame_tick       (frame_tick),
      .move_dir         (move_dir),
      .collision_done   (collision_done),
      .c_map_collision  (c_map_collision),
      .c_e1_collision   (c_e1_collision),
      .char_x           (char_x),
      .char_y           (char_y),
      .direction_char   (direction_char),
      .facing_char      (facing_char),
      .attack           (attack),
      .collision_init   (collision_init),
      .collision_enable (collision_enable),
      .damage           (damage),
      .invuln           (invuln),
      .busy             (busy),
      .update_done      (update_done)
   );

   always #5 clock = ~clock;

   int n_run  = 0;
   int n_fail = 0;

   int m_x, m_y, m_face, m_inv;

   int det_delay = 0;
   int en_cnt    = 0;
   bit det_map   = 1'b0;
   bit det_e1    = 1'b0;

   typedef struct {
      int x;
      int y;
      int face;
      int dmg;
      int lat;
      int inv;
   } exp_t;
   exp_t sb[$];

   // Detector answers in the det_delay-th enabled cycle; 0 = never
   always @(negedge clock) begin
      if (collision_enable) begin
         en_cnt++;
         collision_done  = (en_cnt == det_delay);
         c_map_collision = det_map;
         c_e1_collision  = det_e1;
      end else begin
         en_cnt         = 0;
         collision_done = 1'b0;
      end
   end

   function automatic int clampi(input int v, input int hi);
      return (v < 0) ? 0 : ((v > hi) ? hi : v);
   endfunction

   task automatic do_frame(input int dir, input int dly, input bit mp,
                           input bit e1, input int extra_at);
      exp_t e;
      bit   tmo, emap, hit, got;
      int   n, od, j, dmg_cnt;
      if (m_inv > 0) m_inv--;
      if (extra_at > 0 && m_inv > 0) m_inv--;
      tmo  = (dly < 1) || (dly > 31);
      n    = tmo ? 31 : dly;
      emap = tmo ? 1'b1 : mp;
      hit  = !tmo && e1 && (m_inv == 0);
      if (hit) begin
         od = (m_face == 2) ? 3 : (m_face == 3) ? 2 : (m_face == 4) ? 5 : 4;
         case (od)
            2: m_y -= 8;
            3: m_y += 8;
            4: m_x -= 8;
            default: m_x += 8;
         endcase
         m_inv = 60;
      end else if (dir >= 2 && dir <= 5 && !emap) begin
         case (dir)
            2: m_y -= 1;
            3: m_y += 1;
            4: m_x -= 1;
            default: m_x += 1;
         endcase
      end
      m_x = clampi(m_x, 240);
      m_y = clampi(m_y, 160);
      if (dir >= 2 && dir <= 5) m_face = dir;
      e.x = m_x; e.y = m_y; e.face = m_face;
      e.dmg = hit ? 1 : 0; e.lat = 4 + n; e.inv = (m_inv != 0) ? 1 : 0;
      sb.push_back(e);

      move_dir = 3'(dir);
      det_delay = dly; det_map = mp; det_e1 = e1;
      frame_tick = 1'b1;
      @(negedge clock);
      frame_tick = 1'b0;
      j = 1; got = 1'b0; dmg_cnt = 0;
      while (!got && j < 100) begin
         if (j == 1) begin
            n_run++;
            if (collision_init !== 1'b1 || direction_char !== 3'(dir)
                || attack !== (dir == 1)) begin
               n_fail++;
               $display("FAIL init_cycle init=%b dir=%0d atk=%b want 1/%0d/%b",
                        collision_init, direction_char, attack, dir, dir == 1);
            end
         end
         if (damage === 1'b1) dmg_cnt++;
         if (update_done === 1'b1) got = 1'b1;
         else begin
            frame_tick = (j == extra_at);
            @(negedge clock);
            j++;
         end
      end
      frame_tick = 1'b0;
      e = sb.pop_front();
      n_run++;
      if (!got) begin
         n_fail++;
         $display("FAIL frame_wait no update_done within 100 cycles");
      end
      n_run++;
      if ((1 + j) != e.lat) begin
         n_fail++;
         $display("FAIL latency got %0d want %0d", 1 + j, e.lat);
      end
      n_run++;
      if (char_x !== 9'(e.x) || char_y !== 8'(e.y)) begin
         n_fail++;
         $display("FAIL position got (%0d,%0d) want (%0d,%0d)",
                  char_x, char_y, e.x, e.y);
      end
      n_run++;
      if (facing_char !== 3'(e.face)) begin
         n_fail++;
         $display("FAIL facing got %0d want %0d", facing_char, e.face);
      end
      n_run++;
      if (dmg_cnt != e.dmg) begin
         n_fail++;
         $display("FAIL damage_pulses got %0d want %0d", dmg_cnt, e.dmg);
      end
      n_run++;
      if (invuln !== (e.inv != 0) || attack !== 1'b0) begin
         n_fail++;
         $display("FAIL done_flags invuln=%b attack=%b want %0d/0",
                  invuln, attack, e.inv);
      end
      @(negedge clock);
   endtask

   task automatic check_reset_vals(input string tag);
      n_run++;
      if (char_x !== 9'd120 || char_y !== 8'd80) begin
         n_fail++;
         $display("FAIL %s_pos got (%0d,%0d) want (120,80)", tag, char_x, char_y);
      end
      n_run++;
      if (facing_char !== 3'd3 || direction_char !== 3'd0) begin
         n_fail++;
         $display("FAIL %s_dir got face=%0d dir=%0d want 3/0",
                  tag, facing_char, direction_char);
      end
      n_run++;
      if ({attack, collision_init, collision_enable, damage,
           invuln, busy, update_done} !== 7'b0) begin
         n_fail++;
         $display("FAIL %s_flags got %b want 0000000", tag,
                  {attack, collision_init, collision_enable, damage,
                   invuln, busy, update_done});
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(negedge clock);
      check_reset_vals("reset_held");
      resetn = 1'b1;
      m_x = 120; m_y = 80; m_face = 3; m_inv = 0;
      @(negedge clock);
      check_reset_vals("reset_rel");
   endtask

   task automatic test_basic_move();
      do_frame(5, 16, 1'b0, 1'b0, 0);
      n_run++;
      if (char_x !== 9'd121 || facing_char !== 3'd5) begin
         n_fail++;
         $display("FAIL basic_right got x=%0d face=%0d want 121/5",
                  char_x, facing_char);
      end
      do_frame(1, 2, 1'b0, 1'b0, 0);
      do_frame(0, 3, 1'b0, 1'b0, 0);
      do_frame(3, 1, 1'b1, 1'b0, 0);
      do_frame(2, 5, 1'b0, 1'b0, 0);
   endtask

   task automatic test_top_edge();
      while (m_y > 0) do_frame(2, 1, 1'b0, 1'b0, 0);
      do_frame(2, 2, 1'b1, 1'b0, 0);
      n_run++;
      if (char_y !== 8'd0 || facing_char !== 3'd2) begin
         n_fail++;
         $display("FAIL top_blocked got y=%0d face=%0d want 0/2",
                  char_y, facing_char);
      end
      do_frame(2, 1, 1'b0, 1'b0, 0);
      do_frame(3, 1, 1'b1, 1'b0, 0);
      do_frame(0, 3, 1'b0, 1'b1, 0);
      n_run++;
      if (char_y !== 8'd0) begin
         n_fail++;
         $display("FAIL top_knock_clamp got y=%0d want 0", char_y);
      end
   endtask

   task automatic test_knockback();
      while (m_x > 4) do_frame(4, 1, 1'b0, 1'b0, 0);
      do_frame(4, 2, 1'b0, 1'b1, 0);
      n_run++;
      if (char_x !== 9'd12 || invuln !== 1'b1) begin
         n_fail++;
         $display("FAIL knock_left got x=%0d inv=%b want 12/1", char_x, invuln);
      end
      do_frame(0, 2, 1'b0, 1'b1, 0);
      n_run++;
      if (char_x !== 9'd12) begin
         n_fail++;
         $display("FAIL knock_invuln got x=%0d want 12", char_x);
      end
   endtask

   task automatic test_invuln();
      for (int i = 0; i < 58; i++) do_frame(0, 1, 1'b0, 1'b0, 0);
      n_run++;
      if (invuln !== 1'b1) begin
         n_fail++;
         $display("FAIL invuln_tick59 got %b want 1", invuln);
      end
      do_frame(0, 1, 1'b0, 1'b0, 0);
      n_run++;
      if (invuln !== 1'b0) begin
         n_fail++;
         $display("FAIL invuln_tick60 got %b want 0", invuln);
      end
      do_frame(0, 2, 1'b0, 1'b1, 0);
   endtask

   task automatic test_timeout();
      do_frame(5, 0, 1'b0, 1'b1, 0);
      do_frame(3, 0, 1'b0, 1'b0, 0);
   endtask

   task automatic test_drop();
      int ud;
      do_frame(5, 10, 1'b0, 1'b0, 4);
      ud = 0;
      for (int i = 0; i < 10; i++) begin
         if (update_done === 1'b1 || busy === 1'b1) ud++;
         @(negedge clock);
      end
      n_run++;
      if (ud != 0) begin
         n_fail++;
         $display("FAIL drop_extra got %0d busy/done cycles want 0", ud);
      end
   endtask

   task automatic test_reset_mid();
      int ud;
      move_dir = 3'd5; det_delay = 20; det_map = 1'b0; det_e1 = 1'b0;
      frame_tick = 1'b1;
      @(negedge clock);
      frame_tick = 1'b0;
      repeat (3) @(negedge clock);
      n_run++;
      if (collision_enable !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_in_check got enable=%b want 1", collision_enable);
      end
      #2 resetn = 1'b0;
      #1 check_reset_vals("mid_reset");
      ud = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clock);
         if (update_done === 1'b1) ud++;
      end
      n_run++;
      if (ud != 0) begin
         n_fail++;
         $display("FAIL mid_no_done got %0d pulses want 0", ud);
      end
      resetn = 1'b1;
      m_x = 120; m_y = 80; m_face = 3; m_inv = 0;
      @(negedge clock);
      do_frame(5, 1, 1'b0, 1'b0, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clock);
      test_reset();
      test_basic_move();
      test_top_edge();
      test_knockback();
      test_invuln();
      test_timeout();
      test_drop();
      test_reset_mid();
      n_run++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_left got %0d entries want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
